// File: rtl/pps_seconds_pkg.sv
// Shared types and widths for the PPS-disciplined seconds counter.
package pps_seconds_pkg;

  localparam int unsigned SEC_W = 32;
  localparam int unsigned ERR_W = 16;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2,
    HOLD   = 2'd3
  } pps_state_e;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pps_sync_edge.sv
// Two-flop synchroniser for the asynchronous PPS input plus rising-edge detector.
module pps_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pps_i,
  output logic edge_o
);

  logic [1:0] sync_q;
  logic [1:0] fill_q;
  logic       prev_q;

  // prev_q stays high until the synchroniser has refilled after reset, so a
  // pulse already high at reset release is not reported as an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], pps_i};
      fill_q <= {fill_q[0], 1'b1};
      prev_q <= fill_q[1] ? sync_q[1] : 1'b1;
    end
  end

  assign edge_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/pps_seconds_counter.sv
// Seconds/sub-second time base disciplined by 1PPS, with arm/load and holdover.
module pps_seconds_counter
  import pps_seconds_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 256000000,
  parameter int unsigned TOL      = 16,
  parameter int unsigned SUBSEC_W = 28
) (
  input  logic                user_clk,
  input  logic                user_rst,
  input  logic                pps_in,
  input  logic [SEC_W-1:0]    load_sec,
  input  logic                load_arm,
  output logic [SEC_W-1:0]    seconds,
  output logic [SUBSEC_W-1:0] subsec,
  output logic                sec_tick,
  output logic                locked,
  output logic                holdover,
  output logic [ERR_W-1:0]    pps_err_cnt
);

  localparam logic [SUBSEC_W-1:0] NomLast = SUBSEC_W'(CLK_FREQ - 1);
  localparam logic [SUBSEC_W-1:0] Early   = SUBSEC_W'(CLK_FREQ - 1 - TOL);
  localparam logic [SUBSEC_W-1:0] Late    = SUBSEC_W'(CLK_FREQ - 1 + TOL);
  localparam logic [SUBSEC_W-1:0] Half    = SUBSEC_W'(CLK_FREQ / 2);
  localparam logic [SUBSEC_W-1:0] TolV    = SUBSEC_W'(TOL);

  logic pps_edge;

  pps_sync_edge u_sync_edge (
    .clk_i  (user_clk),
    .rst_i  (user_rst),
    .pps_i  (pps_in),
    .edge_o (pps_edge)
  );

  pps_state_e          state_q, state_d;
  logic [SEC_W-1:0]    sec_q, sec_d;
  logic [SEC_W-1:0]    pend_q, pend_d;
  logic [SUBSEC_W-1:0] sub_q, sub_d;
  logic [SUBSEC_W-1:0] sub_sat;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                tick_q, tick_d;
  logic                locked_q, hold_q;

  assign sub_sat = (&sub_q) ? sub_q : sub_q + 1'b1;

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    pend_d  = pend_q;
    sub_d   = sub_q;
    err_d   = err_q;
    tick_d  = 1'b0;
    case (state_q)
      UNSYNC: begin
        sub_d = pps_edge ? '0 : sub_sat;
      end
      ARMED: begin
        if (pps_edge) begin
          sec_d   = pend_q;
          sub_d   = '0;
          tick_d  = 1'b1;
          state_d = LOCKED;
        end else begin
          sub_d = sub_sat;
        end
      end
      LOCKED: begin
        if (pps_edge) begin
          sec_d  = sec_q + 1'b1;
          sub_d  = '0;
          tick_d = 1'b1;
          if (sub_q < Early || sub_q > Late) err_d = sat_inc(err_q);
        end else if (sub_q == Late) begin
          // Missing PPS: keep the phase of the nominal boundary TOL cycles back.
          sec_d   = sec_q + 1'b1;
          sub_d   = TolV;
          tick_d  = 1'b1;
          err_d   = sat_inc(err_q);
          state_d = HOLD;
        end else begin
          sub_d = sub_q + 1'b1;
        end
      end
      HOLD: begin
        if (pps_edge) begin
          sub_d   = '0;
          state_d = LOCKED;
          // A late return belongs to the second already free-run into.
          if (sub_q >= Half) begin
            sec_d  = sec_q + 1'b1;
            tick_d = 1'b1;
          end
        end else if (sub_q >= NomLast) begin
          sec_d  = sec_q + 1'b1;
          sub_d  = '0;
          tick_d = 1'b1;
        end else begin
          sub_d = sub_q + 1'b1;
        end
      end
      default: state_d = UNSYNC;
    endcase
    if (load_arm) begin
      pend_d  = load_sec;
      state_d = ARMED;
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q  <= UNSYNC;
      sec_q    <= '0;
      pend_q   <= '0;
      sub_q    <= '0;
      err_q    <= '0;
      tick_q   <= 1'b0;
      locked_q <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sec_q    <= sec_d;
      pend_q   <= pend_d;
      sub_q    <= sub_d;
      err_q    <= err_d;
      tick_q   <= tick_d;
      locked_q <= (state_d == LOCKED);
      hold_q   <= (state_d == HOLD);
    end
  end

  assign seconds     = sec_q;
  assign subsec      = sub_q;
  assign sec_tick    = tick_q;
  assign locked      = locked_q;
  assign holdover    = hold_q;
  assign pps_err_cnt = err_q;

endmodule

// File: tb/tb_pps_seconds_counter.sv
// Randomised scoreboard bench: a timeline model predicts every sec_tick and the quiet-time state.
module tb_pps_seconds_counter;

  localparam int ClkFreq = 100;
  localparam int Tol     = 2;
  localparam int SubW    = 8;
  localparam int SubMax  = 255;

  localparam int MUnsync = 0;
  localparam int MArmed  = 1;
  localparam int MLocked = 2;
  localparam int MHold   = 3;

  logic            user_clk = 1'b0;
  logic            user_rst = 1'b1;
  logic            pps_in   = 1'b0;
  logic            load_arm = 1'b0;
  logic [31:0]     load_sec = '0;
  logic [31:0]     seconds;
  logic [SubW-1:0] subsec;
  logic            sec_tick;
  logic            locked;
  logic            holdover;
  logic [15:0]     pps_err_cnt;

  pps_seconds_counter #(
    .CLK_FREQ (ClkFreq),
    .TOL      (Tol),
    .SUBSEC_W (SubW)
  ) dut (
    .user_clk    (user_clk),
    .user_rst    (user_rst),
    .pps_in      (pps_in),
    .load_sec    (load_sec),
    .load_arm    (load_arm),
    .seconds     (seconds),
    .subsec      (subsec),
    .sec_tick    (sec_tick),
    .locked      (locked),
    .holdover    (holdover),
    .pps_err_cnt (pps_err_cnt)
  );

  always #5 user_clk = ~user_clk;

  int cyc = 0;
  always @(posedge user_clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int          cyc;
    logic [31:0] sec;
    int          err;
  } exp_t;
  exp_t sb_q[$];

  // Timeline model: m_bnd is the cycle at which subsec reads 0 for the current second.
  int          m_mode = MUnsync;
  logic [31:0] m_sec  = '0;
  logic [31:0] m_pend = '0;
  int          m_err  = 0;
  int          m_bnd  = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0d required %0d", name, cyc, act, req);
    end
  endtask

  function automatic void push_tick(input int t);
    exp_t e;
    e.cyc = t;
    e.sec = m_sec;
    e.err = m_err;
    sb_q.push_back(e);
  endfunction

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Emit free-running consequences (holdover entry, holdover wraps) up to time t.
  function automatic void model_advance(input int t, input bit incl);
    while (1) begin
      if (m_mode == MLocked &&
          (m_bnd + ClkFreq + Tol < t || (incl && m_bnd + ClkFreq + Tol == t))) begin
        m_sec  = m_sec + 1;
        m_err  = sat16(m_err);
        m_bnd  = m_bnd + ClkFreq;
        m_mode = MHold;
        push_tick(m_bnd + Tol);
      end else if (m_mode == MHold &&
                   (m_bnd + ClkFreq < t || (incl && m_bnd + ClkFreq == t))) begin
        m_bnd = m_bnd + ClkFreq;
        m_sec = m_sec + 1;
        push_tick(m_bnd);
      end else begin
        break;
      end
    end
  endfunction

  // Edge whose effect becomes visible at cycle u; s is subsec in the edge cycle.
  function automatic void model_edge(input int u);
    int s;
    s = u - 1 - m_bnd;
    case (m_mode)
      MArmed: begin
        m_sec  = m_pend;
        m_mode = MLocked;
        push_tick(u);
      end
      MLocked: begin
        if (s < ClkFreq - 1 - Tol || s > ClkFreq - 1 + Tol) m_err = sat16(m_err);
        m_sec = m_sec + 1;
        push_tick(u);
      end
      MHold: begin
        m_mode = MLocked;
        if (s >= ClkFreq / 2) begin
          m_sec = m_sec + 1;
          push_tick(u);
        end
      end
      default: ;
    endcase
    m_bnd = u;
  endfunction

  task automatic check_state(input string tag);
    int exp_sub;
    exp_sub = cyc - m_bnd;
    if ((m_mode == MUnsync || m_mode == MArmed) && exp_sub > SubMax) exp_sub = SubMax;
    chk({tag, "_seconds"}, seconds, m_sec);
    chk({tag, "_subsec"}, subsec, exp_sub);
    chk({tag, "_locked"}, locked, (m_mode == MLocked) ? 1 : 0);
    chk({tag, "_holdover"}, holdover, (m_mode == MHold) ? 1 : 0);
    chk({tag, "_err_cnt"}, pps_err_cnt, m_err);
  endtask

  // One stimulus segment: optional PPS rise at offset gap (4 cycles high) and
  // optional load_arm strobe at offset arm_off; expectations are queued up front.
  task automatic seg(input string tag, input int gap, input bit pulse, input int arm_off,
                     input logic [31:0] val);
    int c0;
    int len;
    int u;
    int a;
    c0  = cyc;
    len = pulse ? gap + 5 : gap;
    u   = c0 + gap + 3;
    a   = c0 + arm_off + 1;
    if (pulse && (arm_off < 0 || u <= a)) begin
      model_advance(u, 1'b0);
      model_edge(u);
      if (arm_off >= 0) begin
        model_advance(a, 1'b1);
        m_pend = val;
        m_mode = MArmed;
      end
    end else begin
      if (arm_off >= 0) begin
        model_advance(a, 1'b1);
        m_pend = val;
        m_mode = MArmed;
      end
      if (pulse) begin
        model_advance(u, 1'b0);
        model_edge(u);
      end
    end
    model_advance(c0 + len, 1'b1);
    for (int i = 0; i < len; i++) begin
      pps_in   = pulse && i >= gap && i < gap + 4;
      load_arm = (i == arm_off);
      load_sec = (i == arm_off) ? val : $urandom;
      @(negedge user_clk);
    end
    load_arm = 1'b0;
    check_state(tag);
  endtask

  task automatic rst_seg(input string tag, input int len, input bit level);
    int c0;
    c0       = cyc;
    user_rst = 1'b1;
    pps_in   = level;
    load_arm = 1'b0;
    @(negedge user_clk);
    chk({tag, "_rst_seconds"}, seconds, 0);
    chk({tag, "_rst_subsec"}, subsec, 0);
    chk({tag, "_rst_tick"}, sec_tick, 0);
    chk({tag, "_rst_locked"}, locked, 0);
    chk({tag, "_rst_holdover"}, holdover, 0);
    chk({tag, "_rst_err_cnt"}, pps_err_cnt, 0);
    repeat (len - 1) @(negedge user_clk);
    user_rst = 1'b0;
    m_mode = MUnsync;
    m_sec  = '0;
    m_pend = '0;
    m_err  = 0;
    m_bnd  = c0 + len;
    repeat (6) @(negedge user_clk);
    pps_in = 1'b0;
    check_state({tag, "_post"});
  endtask

  // Monitor: every sec_tick must match the head of the expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge user_clk);
      #1;
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        checks++;
        fails++;
        $display("FAIL tick_missing: got no sec_tick at cycle %0d, required seconds %0d",
                 sb_q[0].cyc, sb_q[0].sec);
        void'(sb_q.pop_front());
      end
      if (sec_tick === 1'b1) begin
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
          e = sb_q.pop_front();
          chk("tick_seconds", seconds, e.sec);
          chk("tick_err_cnt", pps_err_cnt, e.err);
        end else begin
          checks++;
          fails++;
          $display("FAIL tick_unexpected: got sec_tick=1 at cycle %0d, required 0", cyc);
        end
      end
    end
  end

  initial begin
    int g;
    int r;
    rst_seg("init", 4, 1'b0);

    seg("unsync_a", 20, 1'b1, -1, '0);
    seg("unsync_b", 95, 1'b1, -1, '0);
    seg("unsync_c", 95, 1'b1, -1, '0);
    seg("unsync_sat", 300, 1'b0, -1, '0);
    seg("unsync_d", 40, 1'b1, -1, '0);

    seg("arm_load", 30, 1'b1, 5, 32'd1000);
    seg("locked_100", 95, 1'b1, -1, '0);
    seg("locked_97", 92, 1'b1, -1, '0);
    seg("locked_100b", 95, 1'b1, -1, '0);

    seg("hold_a", 350, 1'b0, -1, '0);
    g = m_bnd + 8 - cyc;
    while (g < 1) g += ClkFreq;
    seg("restore_s10", g, 1'b1, -1, '0);
    seg("relock_a", 95, 1'b1, -1, '0);
    seg("hold_b", 250, 1'b0, -1, '0);
    g = m_bnd + 68 - cyc;
    while (g < 1) g += ClkFreq;
    seg("restore_s70", g, 1'b1, -1, '0);

    seg("coinc_arm", 95, 1'b1, 97, 32'd5);
    seg("coinc_load", 95, 1'b1, -1, '0);

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        seg("rand_pps", $urandom_range(87, 103), 1'b1, -1, '0);
      end else if (r < 8) begin
        seg("rand_gap", $urandom_range(60, 250), 1'b0, -1, '0);
      end else begin
        g = $urandom_range(10, 120);
        seg("rand_arm", g, 1'b1, $urandom_range(0, g + 3), $urandom);
      end
    end

    seg("wrap_arm", 40, 1'b1, 3, 32'hFFFF_FFFF);
    seg("wrap_zero", 95, 1'b1, -1, '0);

    seg("max_arm", 40, 1'b1, 3, 32'hFFFF_FFFE);
    seg("max_hold", 120, 1'b0, -1, '0);
    rst_seg("hold_rst", 3, 1'b1);
    seg("after_rst", 30, 1'b1, -1, '0);

    repeat (5) @(negedge user_clk);
    chk("scoreboard_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
